// File: rtl/seq_serializer.sv
// seq_serializer: one-word-buffered parallel-to-serial shifter; optional even parity bit per frame under `SEQ_SER_PARITY_EN.
// Latency: first bit on seq_out the cycle after the word loads (2 cycles after handshake when idle); back-to-back frames have no gap.
// Backpressure: data_ready = holding register empty (and not in reset); it never depends on data_valid.
module seq_serializer #(
   parameter int WIDTH      = 8,
   parameter bit IDLE_LEVEL = 1'b0,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             seq_out,
   output logic             busy,
   output logic             frame_done
);

`ifdef SEQ_SER_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
   localparam int FRAME_LEN = WIDTH;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif
   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_data_q, hold_data_d;
   logic             hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             seq_out_q, seq_out_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
`ifdef SEQ_SER_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic frame_last;
   logic load;
   logic accept;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   assign data_ready = !hold_valid_q && !reset;
   assign accept     = data_valid && data_ready;

   // The bit on seq_out now is the final one of its frame, so a held word may follow immediately.
   always_comb begin
      frame_last = 1'b0;
      case (state_q)
`ifdef SEQ_SER_PARITY_EN
         ST_PARITY: frame_last = 1'b1;
`else
         ST_SHIFT:  frame_last = (cnt_q == LAST_DATA);
`endif
         default:   frame_last = 1'b0;
      endcase
   end

   assign load = hold_valid_q && ((state_q == ST_IDLE) || frame_last);

   always_comb begin
      state_d      = state_q;
      hold_data_d  = hold_data_q;
      hold_valid_d = hold_valid_q;
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      seq_out_d    = seq_out_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
`ifdef SEQ_SER_PARITY_EN
      parity_d     = parity_q;
`endif

      if (load) begin
         state_d      = ST_SHIFT;
         seq_out_d    = first_bit(hold_data_q);
         shreg_d      = advance(hold_data_q);
         cnt_d        = CW'(1);
         busy_d       = 1'b1;
         hold_valid_d = 1'b0;
`ifdef SEQ_SER_PARITY_EN
         parity_d     = ^hold_data_q;
`endif
      end else begin
         case (state_q)
            ST_SHIFT: begin
               if (cnt_q == LAST_DATA) begin
`ifdef SEQ_SER_PARITY_EN
                  state_d      = ST_PARITY;
                  seq_out_d    = parity_q;
                  frame_done_d = 1'b1;
`else
                  state_d      = ST_IDLE;
                  seq_out_d    = IDLE_LEVEL;
                  busy_d       = 1'b0;
`endif
               end else begin
                  seq_out_d = first_bit(shreg_q);
                  shreg_d   = advance(shreg_q);
                  cnt_d     = cnt_q + CW'(1);
`ifndef SEQ_SER_PARITY_EN
                  frame_done_d = ((cnt_q + CW'(1)) == LAST_DATA);
`endif
               end
            end
`ifdef SEQ_SER_PARITY_EN
            ST_PARITY: begin
               state_d   = ST_IDLE;
               seq_out_d = IDLE_LEVEL;
               busy_d    = 1'b0;
            end
`endif
            default: begin
               state_d   = ST_IDLE;
               seq_out_d = IDLE_LEVEL;
               busy_d    = 1'b0;
            end
         endcase
      end

      // Accept cannot coincide with a load (ready needs an empty buffer), but order keeps it safe anyway.
      if (accept) begin
         hold_data_d  = data_in;
         hold_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
         shreg_q      <= '0;
         cnt_q        <= '0;
         seq_out_q    <= IDLE_LEVEL;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         seq_out_q    <= seq_out_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
`ifdef SEQ_SER_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

   assign seq_out    = seq_out_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: MSB-first and LSB-first instances share one input stream; a queue-based line model predicts every output.
// Latency/backpressure behaviour is checked cycle by cycle at the falling edge.
module tb_seq_serializer;
   localparam int W = 4;
   localparam bit IDLE = 1'b0;
`ifdef SEQ_SER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] data_in;
   logic         data_valid;
   logic         rdy_m, seq_m, busy_m, fd_m;
   logic         rdy_l, seq_l, busy_l, fd_l;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   seq_serializer #(.WIDTH(W), .IDLE_LEVEL(IDLE), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .data_ready(rdy_m), .seq_out(seq_m), .busy(busy_m), .frame_done(fd_m));

   seq_serializer #(.WIDTH(W), .IDLE_LEVEL(IDLE), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .data_ready(rdy_l), .seq_out(seq_l), .busy(busy_l), .frame_done(fd_l));

   // Line model: queue front is the bit currently on seq_out; an empty queue means idle.
   bit           qm[$];
   bit           ql[$];
   bit           held;
   logic [W-1:0] held_word;

   function automatic void push_frame(input logic [W-1:0] w);
      bit par;
      par = ^w;
      for (int i = 0; i < W; i++) begin
         qm.push_back(w[W-1-i]);
         ql.push_back(w[i]);
      end
      if (PAR) begin
         qm.push_back(par);
         ql.push_back(par);
      end
   endfunction

   function automatic void model_edge(input logic v, input logic [W-1:0] d);
      bit hs;
      hs = v && !held;
      if (held && qm.size() <= 1) begin
         qm.delete();
         ql.delete();
         push_frame(held_word);
         held = 1'b0;
      end else if (qm.size() > 0) begin
         void'(qm.pop_front());
         void'(ql.pop_front());
      end
      if (hs) begin
         held      = 1'b1;
         held_word = d;
      end
   endfunction

   function automatic void model_reset();
      qm.delete();
      ql.delete();
      held = 1'b0;
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs(input string ph);
      logic em, el;
      em = (qm.size() != 0) ? qm[0] : IDLE;
      el = (ql.size() != 0) ? ql[0] : IDLE;
      check({ph, ":seq_msb"},   seq_m,  em);
      check({ph, ":busy_msb"},  busy_m, qm.size() != 0);
      check({ph, ":done_msb"},  fd_m,   qm.size() == 1);
      check({ph, ":ready_msb"}, rdy_m,  !held);
      check({ph, ":seq_lsb"},   seq_l,  el);
      check({ph, ":busy_lsb"},  busy_l, ql.size() != 0);
      check({ph, ":done_lsb"},  fd_l,   ql.size() == 1);
      check({ph, ":ready_lsb"}, rdy_l,  !held);
   endtask

   // Called just after a falling edge: drive, clock, update model, check at next falling edge.
   task automatic do_cycle(input string ph, input logic v, input logic [W-1:0] d);
      data_valid = v;
      data_in    = d;
      @(posedge clk);
      model_edge(v, d);
      @(negedge clk);
      check_outputs(ph);
   endtask

   task automatic reset_checks(input string ph);
      check({ph, ":seq_msb"},   seq_m,  IDLE);
      check({ph, ":busy_msb"},  busy_m, 1'b0);
      check({ph, ":done_msb"},  fd_m,   1'b0);
      check({ph, ":ready_msb"}, rdy_m,  1'b0);
      check({ph, ":seq_lsb"},   seq_l,  IDLE);
      check({ph, ":ready_lsb"}, rdy_l,  1'b0);
   endtask

   initial begin
      logic [W-1:0] words[2];
      int k;
      int done_cnt;
      bit busy_gap;
      logic v;

      reset      = 1'b1;
      data_valid = 1'b0;
      data_in    = '0;
      model_reset();

      // Reset and idle.
      @(negedge clk);
      reset_checks("por");
      reset = 1'b0;
      #1;
      check("post_reset:ready", rdy_m, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) do_cycle("idle", 1'b0, 4'hF);

      // Single word 1011, then LSB-visible word 0001.
      do_cycle("single_a", 1'b1, 4'b1011);
      for (int i = 0; i < W + 3; i++) do_cycle("single_a", 1'b0, '0);
      do_cycle("single_b", 1'b1, 4'b0001);
      for (int i = 0; i < W + 3; i++) do_cycle("single_b", 1'b0, '0);

      // Back-to-back with data_valid held high; busy must not drop between frames.
      words[0] = 4'b1101;
      words[1] = 4'b0110;
      k = 0;
      done_cnt = 0;
      busy_gap = 1'b0;
      for (int i = 0; i < 2 * (W + 1) + 6; i++) begin
         v = (k < 2);
         if (v && !held) begin
            do_cycle("b2b", 1'b1, words[k]);
            k++;
         end else begin
            do_cycle("b2b", v, (k < 2) ? words[k] : 4'h0);
         end
         if (fd_m) done_cnt++;
         if (done_cnt < 2 && k == 2 && qm.size() != 0 && !busy_m) busy_gap = 1'b1;
      end
      check("b2b:frame_done_count", done_cnt == 2, 1'b1);
      check("b2b:busy_gap", busy_gap, 1'b0);

      // Backpressure and random traffic: data_in churns every cycle regardless of acceptance.
      for (int i = 0; i < 400; i++) begin
         do_cycle("rand", ($urandom_range(0, 3) != 0), W'($urandom));
      end
      for (int i = 0; i < 2 * W + 4; i++) do_cycle("drain", 1'b0, W'($urandom));

      // Mid-frame reset after two bits of 1011, with 0101 held behind it.
      do_cycle("mid", 1'b1, 4'b1011);
      do_cycle("mid", 1'b1, 4'b0101);
      do_cycle("mid", 1'b1, 4'b0101);
      data_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      reset_checks("midrst");
      model_reset();
      @(negedge clk);
      reset_checks("midrst_hold");
      reset = 1'b0;
      #1;
      check("midrst_release:ready", rdy_l, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 2 * W + 3; i++) do_cycle("after_rst", 1'b0, 4'hA);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
